// File: rtl/sdram_wb_arbiter_if.sv
// Bus bundle between the Wishbone requesters, the arbiter and the SDRAM controller user port.
// The arbiter uses the slave modport; the requester/controller side uses the master modport.
interface sdram_wb_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS*24-1:0] req_adr;
    logic [NUM_PORTS*16-1:0] req_dat_w;
    logic [NUM_PORTS*2-1:0]  req_sel;
    logic [NUM_PORTS-1:0]    req_we;
    logic [NUM_PORTS-1:0]    req_cyc;
    logic [NUM_PORTS-1:0]    req_stb;
    logic [15:0]             req_dat_r;
    logic [NUM_PORTS-1:0]    req_ack;
    logic [NUM_PORTS-1:0]    req_err;
    logic [23:0]             wb_adr;
    logic [15:0]             wb_dat_w;
    logic [1:0]              wb_sel;
    logic                    wb_we;
    logic                    wb_cyc;
    logic                    wb_stb;
    logic [15:0]             wb_dat_r;
    logic                    wb_ack;
    logic                    wb_err;
    logic [NUM_PORTS-1:0]    grant;
    logic [7:0]              timeout_cnt;

    modport slave (
        input  req_adr, req_dat_w, req_sel, req_we, req_cyc, req_stb,
        input  wb_dat_r, wb_ack, wb_err,
        output req_dat_r, req_ack, req_err,
        output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        output grant, timeout_cnt
    );

    modport master (
        output req_adr, req_dat_w, req_sel, req_we, req_cyc, req_stb,
        output wb_dat_r, wb_ack, wb_err,
        input  req_dat_r, req_ack, req_err,
        input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        input  grant, timeout_cnt
    );
endinterface

// File: rtl/sdram_wb_arbiter.sv
// Round-robin Wishbone classic arbiter in front of the single SDRAM controller user port,
// one outstanding transaction at a time, with a watchdog that ends hung cycles with err.
module sdram_wb_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_done,
    sdram_wb_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_PORTS > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_gidx;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [NUM_PORTS-1:0]   r_ack;
    logic [NUM_PORTS-1:0]   r_err;
    logic [15:0]            r_dat_r;
    logic [23:0]            r_wb_adr;
    logic [15:0]            r_wb_dat_w;
    logic [1:0]             r_wb_sel;
    logic                   r_wb_we;
    logic                   r_wb_cyc;
    logic [7:0]             r_tcnt;

    logic [23:0]            w_adr   [NUM_PORTS];
    logic [15:0]            w_dat_w [NUM_PORTS];
    logic [1:0]             w_sel   [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_cand;
    logic                   w_found;
    logic [PTR_W-1:0]       w_pick;
    logic [PTR_W-1:0]       w_idx;
    logic [TIMEOUT_W-1:0]   w_wdog_inc;
    logic                   w_cyc_g;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign w_adr[gi]   = bus.req_adr[gi*24 +: 24];
            assign w_dat_w[gi] = bus.req_dat_w[gi*16 +: 16];
            assign w_sel[gi]   = bus.req_sel[gi*2 +: 2];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PTR_W'(s);
    endfunction

    assign w_cand     = bus.req_cyc & bus.req_stb;
    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_cyc_g    = bus.req_cyc[r_gidx];

    // First candidate at or after the pointer, wrapping around the port list.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = wrap_idx(r_ptr, k);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_wdog     <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_dat_r    <= '0;
            r_wb_adr   <= '0;
            r_wb_dat_w <= '0;
            r_wb_sel   <= '0;
            r_wb_we    <= 1'b0;
            r_wb_cyc   <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                IDLE: begin
                    if (init_done && w_found) begin
                        r_wb_adr   <= w_adr[w_pick];
                        r_wb_dat_w <= w_dat_w[w_pick];
                        r_wb_sel   <= w_sel[w_pick];
                        r_wb_we    <= bus.req_we[w_pick];
                        r_wb_cyc   <= 1'b1;
                        r_gidx     <= w_pick;
                        r_grant    <= NUM_PORTS'(1) << w_pick;
                        r_wdog     <= '0;
                        r_state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    r_wdog <= w_wdog_inc;
                    // An abandoned cycle swallows any late controller response.
                    if (!w_cyc_g) begin
                        r_wb_cyc <= 1'b0;
                        r_state  <= DONE;
                    end else if (bus.wb_err) begin
                        r_err    <= r_grant;
                        r_wb_cyc <= 1'b0;
                        r_state  <= DONE;
                    end else if (bus.wb_ack) begin
                        r_dat_r  <= bus.wb_dat_r;
                        r_ack    <= r_grant;
                        r_wb_cyc <= 1'b0;
                        r_state  <= DONE;
                    end else if (&w_wdog_inc) begin
                        r_err    <= r_grant;
                        r_wb_cyc <= 1'b0;
                        if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_grant <= '0;
                    r_ptr   <= (r_gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_gidx + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_dat_r   = r_dat_r;
    assign bus.req_ack     = r_ack;
    assign bus.req_err     = r_err;
    assign bus.wb_adr      = r_wb_adr;
    assign bus.wb_dat_w    = r_wb_dat_w;
    assign bus.wb_sel      = r_wb_sel;
    assign bus.wb_we       = r_wb_we;
    assign bus.wb_cyc      = r_wb_cyc;
    assign bus.wb_stb      = r_wb_cyc;
    assign bus.grant       = r_grant;
    assign bus.timeout_cnt = r_tcnt;
endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Scenario bench for sdram_wb_arbiter: each task drives one feature and checks the
// outputs against a transaction-level round-robin model held in exp_* variables.
module tb_sdram_wb_arbiter;
    localparam int NP = 3;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_done = 1'b0;
    always #5 clk = ~clk;

    sdram_wb_arbiter_if #(.NUM_PORTS(NP)) bus();

    sdram_wb_arbiter #(.NUM_PORTS(NP), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int exp_ptr = 0;
    int exp_tcnt = 0;
    logic [15:0] exp_dat_r = '0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic on, input logic we, input logic [23:0] adr,
                           input logic [15:0] dat, input logic [1:0] sel);
        logic [NP-1:0] m;
        m = NP'(1) << p;
        bus.req_cyc = on ? (bus.req_cyc | m) : (bus.req_cyc & ~m);
        bus.req_stb = on ? (bus.req_stb | m) : (bus.req_stb & ~m);
        bus.req_we  = we ? (bus.req_we | m) : (bus.req_we & ~m);
        bus.req_adr[p*24 +: 24]  = adr;
        bus.req_dat_w[p*16 +: 16] = dat;
        bus.req_sel[p*2 +: 2]    = sel;
    endtask

    task automatic clear_reqs();
        bus.req_cyc = '0;
        bus.req_stb = '0;
    endtask

    task automatic wait_cyc(output int n);
        n = 0;
        while (bus.wb_cyc !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
    endtask

    // Round-robin rule: first requesting port at or after ptr, wrapping.
    function automatic int pick(input logic [NP-1:0] mask, input int ptr);
        for (int k = 0; k < NP; k++)
            if (((mask >> ((ptr + k) % NP)) & 1) != 0) return (ptr + k) % NP;
        return -1;
    endfunction

    task automatic test_reset();
        bus.req_adr = '0; bus.req_dat_w = '0; bus.req_sel = '0; bus.req_we = '0;
        bus.req_cyc = '0; bus.req_stb = '0;
        bus.wb_dat_r = '0; bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
        rst = 1'b0; init_done = 1'b0;
        tick(); tick();
        checks++; if (bus.wb_cyc !== 1'b0 || bus.wb_stb !== 1'b0)
            begin failures++; $display("FAIL reset_cyc: got cyc=%b stb=%b want 0 0", bus.wb_cyc, bus.wb_stb); end
        checks++; if (bus.grant !== '0)
            begin failures++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
        checks++; if (bus.req_ack !== '0 || bus.req_err !== '0)
            begin failures++; $display("FAIL reset_ackerr: got ack=%b err=%b want 0 0", bus.req_ack, bus.req_err); end
        checks++; if (bus.timeout_cnt !== 8'd0 || bus.req_dat_r !== 16'd0 || bus.wb_adr !== 24'd0)
            begin failures++; $display("FAIL reset_regs: got tcnt=%h dat_r=%h adr=%h want 0", bus.timeout_cnt, bus.req_dat_r, bus.wb_adr); end
        rst = 1'b1;
        exp_ptr = 0; exp_tcnt = 0; exp_dat_r = '0;
        tick();
    endtask

    task automatic test_init_hold();
        int bad;
        bad = 0;
        set_req(0, 1'b1, 1'b0, 24'h0ABCDE, 16'h0, 2'b11);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.wb_cyc !== 1'b0 || bus.grant !== '0) begin
                failures++;
                $display("FAIL init_hold: cycle %0d got cyc=%b grant=%b want 0 0", i, bus.wb_cyc, bus.grant);
            end
        end
        init_done = 1'b1;
        tick();
        checks++; if (bus.wb_cyc !== 1'b1 || bus.wb_adr !== 24'h0ABCDE || bus.grant !== 3'b001)
            begin failures++; $display("FAIL init_grant: got cyc=%b adr=%h grant=%b want 1 0abcde 001", bus.wb_cyc, bus.wb_adr, bus.grant); end
        bus.wb_dat_r = 16'h3C3C; bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        set_req(0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        checks++; if (bus.req_ack !== 3'b001 || bus.req_dat_r !== 16'h3C3C)
            begin failures++; $display("FAIL init_ack: got ack=%b dat=%h want 001 3c3c", bus.req_ack, bus.req_dat_r); end
        exp_dat_r = 16'h3C3C; exp_ptr = 1;
        tick();
        checks++; if (bus.grant !== '0 || bus.req_ack !== '0)
            begin failures++; $display("FAIL init_idle: got grant=%b ack=%b want 0 0", bus.grant, bus.req_ack); end
    endtask

    task automatic test_write();
        int n, acks;
        acks = 0;
        set_req(1, 1'b1, 1'b1, 24'h000123, 16'hBEEF, 2'b11);
        wait_cyc(n);
        checks++; if (n != 1)
            begin failures++; $display("FAIL write_latency: got %0d cycles want 1", n); end
        checks++; if (bus.grant !== 3'b010 || bus.wb_we !== 1'b1 || bus.wb_dat_w !== 16'hBEEF ||
                      bus.wb_adr !== 24'h000123 || bus.wb_sel !== 2'b11)
            begin failures++; $display("FAIL write_bus: got grant=%b we=%b dat=%h adr=%h sel=%b want 010 1 beef 000123 11",
                                       bus.grant, bus.wb_we, bus.wb_dat_w, bus.wb_adr, bus.wb_sel); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.req_ack !== '0) acks++;
            checks++; if (bus.wb_cyc !== 1'b1 || bus.wb_dat_w !== 16'hBEEF)
                begin failures++; $display("FAIL write_hold: got cyc=%b dat=%h want 1 beef", bus.wb_cyc, bus.wb_dat_w); end
        end
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        set_req(1, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        checks++; if (bus.req_ack !== 3'b010)
            begin failures++; $display("FAIL write_ack: got %b want 010", bus.req_ack); end
        if (bus.req_ack !== '0) acks++;
        tick(); if (bus.req_ack !== '0) acks++;
        tick(); if (bus.req_ack !== '0) acks++;
        checks++; if (acks != 1)
            begin failures++; $display("FAIL write_ack_count: got %0d want 1", acks); end
        exp_ptr = 2;
    endtask

    task automatic test_alternate();
        int n, g;
        logic [NP-1:0] eg;
        logic [15:0] d;
        set_req(0, 1'b1, 1'b0, 24'h000010, 16'h0, 2'b11);
        set_req(1, 1'b1, 1'b0, 24'h000020, 16'h0, 2'b11);
        for (int t = 0; t < 4; t++) begin
            g = pick(3'b011, exp_ptr);
            eg = NP'(1) << g;
            wait_cyc(n);
            checks++; if (bus.wb_cyc !== 1'b1 || bus.grant !== eg || bus.wb_adr !== 24'(16 * (g + 1)))
                begin failures++; $display("FAIL alt_grant: txn %0d got cyc=%b grant=%b adr=%h want 1 %b %h",
                                           t, bus.wb_cyc, bus.grant, bus.wb_adr, eg, 24'(16 * (g + 1))); end
            d = 16'(16'h1111 * (g + 1));
            bus.wb_dat_r = d; bus.wb_ack = 1'b1;
            tick();
            bus.wb_ack = 1'b0;
            checks++; if (bus.req_ack !== eg || bus.req_dat_r !== d)
                begin failures++; $display("FAIL alt_ack: txn %0d got ack=%b dat=%h want %b %h", t, bus.req_ack, bus.req_dat_r, eg, d); end
            exp_dat_r = d;
            exp_ptr = (g + 1) % NP;
        end
        clear_reqs();
        tick(); tick();
    endtask

    task automatic test_random();
        logic [23:0] ra [NP];
        logic [15:0] rdw [NP];
        logic [1:0]  rs [NP];
        logic        rw [NP];
        logic [NP-1:0] mask, eg;
        logic [15:0] rd;
        int n, g, dly;
        logic is_err;
        for (int it = 0; it < 24; it++) begin
            mask = NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) begin
                ra[p] = 24'($urandom); rdw[p] = 16'($urandom); rs[p] = 2'($urandom); rw[p] = 1'($urandom);
                set_req(p, ((mask >> p) & 1) != 0, rw[p], ra[p], rdw[p], rs[p]);
            end
            g = pick(mask, exp_ptr);
            eg = NP'(1) << g;
            wait_cyc(n);
            checks++; if (bus.wb_cyc !== 1'b1 || bus.grant !== eg || bus.wb_adr !== ra[g] || bus.wb_we !== rw[g] ||
                          bus.wb_dat_w !== rdw[g] || bus.wb_sel !== rs[g])
                begin failures++; $display("FAIL rand_bus: txn %0d got cyc=%b grant=%b adr=%h we=%b dat=%h sel=%b want 1 %b %h %b %h %b",
                                           it, bus.wb_cyc, bus.grant, bus.wb_adr, bus.wb_we, bus.wb_dat_w, bus.wb_sel,
                                           eg, ra[g], rw[g], rdw[g], rs[g]); end
            dly = $urandom_range(0, 6);
            repeat (dly) tick();
            is_err = ($urandom_range(0, 3) == 0);
            rd = 16'($urandom);
            bus.wb_dat_r = rd; bus.wb_ack = !is_err; bus.wb_err = is_err;
            tick();
            bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
            if (is_err) begin
                checks++; if (bus.req_err !== eg || bus.req_ack !== '0 || bus.req_dat_r !== exp_dat_r)
                    begin failures++; $display("FAIL rand_err: txn %0d got err=%b ack=%b dat=%h want %b 0 %h",
                                               it, bus.req_err, bus.req_ack, bus.req_dat_r, eg, exp_dat_r); end
            end else begin
                checks++; if (bus.req_ack !== eg || bus.req_err !== '0 || bus.req_dat_r !== rd)
                    begin failures++; $display("FAIL rand_ack: txn %0d got ack=%b err=%b dat=%h want %b 0 %h",
                                               it, bus.req_ack, bus.req_err, bus.req_dat_r, eg, rd); end
                exp_dat_r = rd;
            end
            exp_ptr = (g + 1) % NP;
        end
        clear_reqs();
        tick(); tick();
    endtask

    task automatic test_timeout();
        int n, k;
        set_req(2, 1'b1, 1'b0, 24'h00F00D, 16'h0, 2'b11);
        wait_cyc(n);
        k = 0;
        while (bus.req_err === '0 && k < 30) begin
            tick();
            k++;
        end
        set_req(2, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        checks++; if (k != 15)
            begin failures++; $display("FAIL timeout_latency: got %0d cycles want 15", k); end
        checks++; if (bus.req_err !== 3'b100 || bus.req_ack !== '0 || bus.wb_cyc !== 1'b0)
            begin failures++; $display("FAIL timeout_err: got err=%b ack=%b cyc=%b want 100 0 0", bus.req_err, bus.req_ack, bus.wb_cyc); end
        checks++; if (bus.timeout_cnt !== 8'(exp_tcnt + 1))
            begin failures++; $display("FAIL timeout_cnt: got %0d want %0d", bus.timeout_cnt, exp_tcnt + 1); end
        exp_tcnt++;
        exp_ptr = 0;
        tick(); tick();
    endtask

    task automatic test_ack_err();
        int n;
        set_req(0, 1'b1, 1'b0, 24'h000777, 16'h0, 2'b01);
        wait_cyc(n);
        bus.wb_dat_r = 16'hDEAD; bus.wb_ack = 1'b1; bus.wb_err = 1'b1;
        tick();
        bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
        set_req(0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        checks++; if (bus.req_err !== 3'b001 || bus.req_ack !== '0)
            begin failures++; $display("FAIL ackerr_prio: got err=%b ack=%b want 001 0", bus.req_err, bus.req_ack); end
        checks++; if (bus.req_dat_r !== exp_dat_r || bus.timeout_cnt !== 8'(exp_tcnt))
            begin failures++; $display("FAIL ackerr_hold: got dat=%h tcnt=%0d want %h %0d", bus.req_dat_r, bus.timeout_cnt, exp_dat_r, exp_tcnt); end
        exp_ptr = 1;
        tick(); tick();
    endtask

    task automatic test_cyc_drop();
        int n, g;
        logic [NP-1:0] eg;
        set_req(1, 1'b1, 1'b0, 24'h000456, 16'h0, 2'b11);
        wait_cyc(n);
        tick();
        checks++; if (bus.wb_cyc !== 1'b1 || bus.grant !== 3'b010)
            begin failures++; $display("FAIL drop_active: got cyc=%b grant=%b want 1 010", bus.wb_cyc, bus.grant); end
        set_req(1, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        bus.wb_dat_r = 16'h5A5A; bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        checks++; if (bus.wb_cyc !== 1'b0 || bus.req_ack !== '0 || bus.req_err !== '0 || bus.req_dat_r !== exp_dat_r)
            begin failures++; $display("FAIL drop_bus: got cyc=%b ack=%b err=%b dat=%h want 0 0 0 %h",
                                       bus.wb_cyc, bus.req_ack, bus.req_err, bus.req_dat_r, exp_dat_r); end
        tick();
        checks++; if (bus.req_ack !== '0 || bus.req_err !== '0)
            begin failures++; $display("FAIL drop_quiet: got ack=%b err=%b want 0 0", bus.req_ack, bus.req_err); end
        exp_ptr = 2;
        set_req(1, 1'b1, 1'b0, 24'h000011, 16'h0, 2'b11);
        set_req(2, 1'b1, 1'b0, 24'h000022, 16'h0, 2'b11);
        g = pick(3'b110, exp_ptr);
        eg = NP'(1) << g;
        wait_cyc(n);
        checks++; if (bus.grant !== eg)
            begin failures++; $display("FAIL drop_rotate: got grant=%b want %b", bus.grant, eg); end
        bus.wb_dat_r = 16'h0F0F; bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        clear_reqs();
        exp_dat_r = 16'h0F0F;
        exp_ptr = (g + 1) % NP;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        int n, g;
        logic [NP-1:0] eg;
        set_req(0, 1'b1, 1'b0, 24'h000100, 16'h0, 2'b11);
        wait_cyc(n);
        bus.wb_dat_r = 16'h7777; bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        clear_reqs();
        tick(); tick();
        set_req(2, 1'b1, 1'b0, 24'h000200, 16'h0, 2'b11);
        wait_cyc(n);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.wb_cyc !== 1'b0 || bus.wb_stb !== 1'b0 || bus.grant !== '0)
            begin failures++; $display("FAIL async_bus: got cyc=%b stb=%b grant=%b want 0 0 0", bus.wb_cyc, bus.wb_stb, bus.grant); end
        checks++; if (bus.timeout_cnt !== 8'd0 || bus.req_dat_r !== 16'd0 || bus.wb_adr !== 24'd0)
            begin failures++; $display("FAIL async_regs: got tcnt=%0d dat=%h adr=%h want 0", bus.timeout_cnt, bus.req_dat_r, bus.wb_adr); end
        clear_reqs();
        tick();
        rst = 1'b1;
        exp_ptr = 0; exp_tcnt = 0; exp_dat_r = '0;
        set_req(0, 1'b1, 1'b0, 24'h000300, 16'h0, 2'b11);
        set_req(1, 1'b1, 1'b0, 24'h000400, 16'h0, 2'b11);
        g = pick(3'b011, exp_ptr);
        eg = NP'(1) << g;
        wait_cyc(n);
        checks++; if (bus.grant !== eg)
            begin failures++; $display("FAIL async_ptr: got grant=%b want %b", bus.grant, eg); end
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        clear_reqs();
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_init_hold();
        test_write();
        test_alternate();
        test_random();
        test_timeout();
        test_ack_err();
        test_cyc_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Round-robin Wishbone classic arbiter sharing the single SDRAM controller user port (24-bit word address, 16-bit data, 2-bit select) between NUM_PORTS requesters in the sdram_controller user clock domain.
- Holds all requests until SDRAM init completes and latches one requester per transaction.
- Forwards the requester's cycle to the controller and returns ack/err, with a watchdog timeout that terminates hung cycles with err.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..4).
- TIMEOUT_W, 10, watchdog counter width; a timeout fires after 2^TIMEOUT_W-1 cycles in ACTIVE.

Ports:
- clk  in  1  user clock from sdram_controller (user_clk).
- rst  in  1  asynchronous, active-low reset.
- init_done  in  1  SDRAM init complete; no grant while low.
- req_adr  in  NUM_PORTS*24  requester addresses; port i occupies bits [24i+23:24i].
- req_dat_w  in  NUM_PORTS*16  requester write data.
- req_sel  in  NUM_PORTS*2  requester byte selects.
- req_we  in  NUM_PORTS  write enables.
- req_cyc  in  NUM_PORTS  cycle signals.
- req_stb  in  NUM_PORTS  strobe signals.
- req_dat_r  out  16  read data, shared by all requesters; valid with req_ack.
- req_ack  out  NUM_PORTS  per-port ack pulse.
- req_err  out  NUM_PORTS  per-port error pulse.
- wb_adr  out  24  to user_port_wishbone_0_adr.
- wb_dat_w  out  16  to user_port_wishbone_0_dat_w.
- wb_sel  out  2  to user_port_wishbone_0_sel.
- wb_we  out  1  to user_port_wishbone_0_we.
- wb_cyc  out  1  to user_port_wishbone_0_cyc.
- wb_stb  out  1  to user_port_wishbone_0_stb.
- wb_dat_r  in  16  from user_port_wishbone_0_dat_r.
- wb_ack  in  1  from user_port_wishbone_0_ack.
- wb_err  in  1  from user_port_wishbone_0_err.
- grant  out  NUM_PORTS  one-hot current owner; 0 when idle.
- timeout_cnt  out  8  saturating count of watchdog timeouts.

Behaviour:
- All outputs are registered. Reset (rst low, asynchronous) clears every output to 0, sets state IDLE and sets the round-robin pointer to 0.
- IDLE:
  - A port is a candidate when req_cyc[i] & req_stb[i].
  - If init_done=1 and any candidate exists, grant the first candidate at or after the pointer, scanning with wrap modulo NUM_PORTS.
  - On the next edge: latch that port's adr/dat_w/sel/we onto the wb_* outputs, set wb_cyc=wb_stb=1, set grant one-hot, clear the watchdog, go ACTIVE.
  - Latency from request to wb_stb is 1 cycle.
- ACTIVE:
  - wb_* outputs are held stable; the watchdog increments each cycle.
  - wb_ack=1: capture wb_dat_r into req_dat_r, pulse req_ack[g] for 1 cycle, drop wb_cyc/wb_stb, go DONE.
  - wb_err=1, or wb_ack and wb_err together: pulse req_err[g] only and drop the bus. err takes priority over ack.
  - Watchdog all-ones with no ack or err: pulse req_err[g], drop the bus, increment timeout_cnt (saturates at 255), go DONE.
  - Requester drops req_cyc[g] mid-cycle: drop the bus with no ack or err, go DONE. If the controller's ack arrives in that same cycle, it is discarded.
- DONE:
  - Lasts 1 cycle; the ack/err pulse is visible to the requester here.
  - grant is cleared; the pointer is set to g+1 modulo NUM_PORTS; go IDLE.
  - The requester's stb may still be high in DONE. It is not re-granted until IDLE, where the rotated pointer gives other ports priority.
- req_dat_r holds its last value when no ack is pulsed.
- init_done falling mid-cycle does not abort the current transaction; it only blocks new grants.
- Each transaction occupies at least 3 cycles (IDLE, ACTIVE, DONE). No pipelining; single outstanding transaction.

Test Plan:
- Reset with init_done=0 and port 0 requesting -> wb_cyc stays 0 and grant=0 for 20 cycles. Raise init_done -> wb_cyc=1 one cycle later with wb_adr equal to port 0's address.
- Port 1 writes adr 0x000123, dat 0xBEEF, sel 2'b11; controller acks after 4 cycles -> wb_we=1, wb_dat_w=0xBEEF; req_ack[1] pulses exactly once, the cycle after wb_ack.
- Ports 0 and 1 both request reads continuously -> grants alternate 0,1,0,1. Each req_ack carries that port's wb_dat_r value, e.g. 0x1111 then 0x2222.
- Controller never acks, TIMEOUT_W=4 -> req_err pulses 15 cycles after wb_stb rises; timeout_cnt=1; wb_cyc drops.
- wb_ack and wb_err asserted in the same cycle -> req_err pulses, req_ack stays 0.
- Requester drops cyc in the 2nd ACTIVE cycle -> wb_cyc falls next edge with no ack/err. Asserting rst mid-ACTIVE -> all outputs 0 immediately, without waiting for a clock edge.
